// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS datapath write-back and register file.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO    = 5'd0;
    localparam logic      WB_SEL_ALU  = 1'b0;
    localparam logic      WB_SEL_MEM  = 1'b1;
    localparam logic      ADDR_SEL_RT = 1'b0;
    localparam logic      ADDR_SEL_RD = 1'b1;

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back and decode-read bundle between the pipeline and the register file.
interface wb_regfile_if;
    import mips_pkg::*;

    word_t     ALU_result;
    word_t     mem_data;
    logic      wb_write_en;
    logic      wb_addr_sel;
    logic      wb_data_sel;
    reg_addr_t wb_addr1;
    reg_addr_t wb_addr2;
    reg_addr_t rs_addr;
    reg_addr_t rt_addr;
    word_t     rs_data;
    word_t     rt_data;
    reg_addr_t wb_addr;
    word_t     wb_data;
    logic      wb_valid;

    modport master (
        output ALU_result, mem_data, wb_write_en, wb_addr_sel, wb_data_sel,
        output wb_addr1, wb_addr2, rs_addr, rt_addr,
        input  rs_data, rt_data, wb_addr, wb_data, wb_valid
    );

    modport slave (
        input  ALU_result, mem_data, wb_write_en, wb_addr_sel, wb_data_sel,
        input  wb_addr1, wb_addr2, rs_addr, rt_addr,
        output rs_data, rt_data, wb_addr, wb_data, wb_valid
    );

endinterface

// File: rtl/wb_mux.sv
// Resolves the write-back destination, data and validity from the MEM/WB selects.
module wb_mux
    import mips_pkg::*;
(
    input  logic      wb_write_en,
    input  logic      wb_addr_sel,
    input  logic      wb_data_sel,
    input  reg_addr_t wb_addr1,
    input  reg_addr_t wb_addr2,
    input  word_t     ALU_result,
    input  word_t     mem_data,
    output reg_addr_t wb_addr,
    output word_t     wb_data,
    output logic      wb_valid
);

    assign wb_addr  = (wb_addr_sel == ADDR_SEL_RD) ? wb_addr2 : wb_addr1;
    assign wb_data  = (wb_data_sel == WB_SEL_MEM) ? mem_data : ALU_result;
    // r0 is hardwired, so a write aimed at it is never a real write
    assign wb_valid = wb_write_en && (wb_addr != REG_ZERO);

endmodule

// File: rtl/wb_regfile.sv
// 32x32 register file with two combinational read ports and write-through bypass.
module wb_regfile
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);

    reg_addr_t wb_addr;
    word_t     wb_data;
    logic      wb_valid;

    wb_mux u_wb_mux (
        .wb_write_en (bus.wb_write_en),
        .wb_addr_sel (bus.wb_addr_sel),
        .wb_data_sel (bus.wb_data_sel),
        .wb_addr1    (bus.wb_addr1),
        .wb_addr2    (bus.wb_addr2),
        .ALU_result  (bus.ALU_result),
        .mem_data    (bus.mem_data),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_valid    (wb_valid)
    );

    assign bus.wb_addr  = wb_addr;
    assign bus.wb_data  = wb_data;
    assign bus.wb_valid = wb_valid;

    // Per-register write strobes; r0 has none, so it can never be written.
    logic  [DEPTH-1:1] wr_sel;
    word_t             regs_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wb_valid && (wb_addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    regs_reg[i] <= wb_data;
                end
            end
        end
    end

    // Reads bypass the pending write so decode sees it without a stall;
    // everything is forced to zero while reset is held.
    function automatic word_t read_port(input reg_addr_t addr);
        word_t data;
        data = '0;
        if (reset && (addr != REG_ZERO)) begin
            if (wb_valid && (addr == wb_addr)) begin
                data = wb_data;
            end else begin
                data = regs_reg[addr];
            end
        end
        return data;
    endfunction

    assign bus.rs_data = read_port(bus.rs_addr);
    assign bus.rt_data = read_port(bus.rt_addr);

endmodule

// File: tb/tb_wb_regfile.sv
// Directed-vector bench for wb_regfile: reset, write-back selects, bypass, r0, async reset.
`timescale 1ns/10ps
module tb_wb_regfile;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    wb_regfile_if bus_if ();

    wb_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_wb(input logic en, input logic asel, input logic [4:0] a1,
                            input logic [4:0] a2, input logic dsel,
                            input logic [31:0] alu, input logic [31:0] mem);
        bus_if.wb_write_en = en;
        bus_if.wb_addr_sel = asel;
        bus_if.wb_addr1    = a1;
        bus_if.wb_addr2    = a2;
        bus_if.wb_data_sel = dsel;
        bus_if.ALU_result  = alu;
        bus_if.mem_data    = mem;
    endtask

    task automatic idle();
        bus_if.wb_write_en = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] rs, input logic [4:0] rt);
        bus_if.rs_addr = rs;
        bus_if.rt_addr = rt;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        drive_wb(1'b1, 1'b1, 5'd0, 5'd4, 1'b0, 32'h0000_0055, 32'h0);
        set_rd(5'd4, 5'd4);

        // Reset held: write is presented but blocked, reads forced to 0
        check("rst_rs4", bus_if.rs_data, 32'h0);
        check("rst_rt4", bus_if.rt_data, 32'h0);
        check("rst_wb_addr", {27'h0, bus_if.wb_addr}, 32'd4);
        check("rst_wb_data", bus_if.wb_data, 32'h0000_0055);
        tick();
        tick();
        check("rst_hold_rs4", bus_if.rs_data, 32'h0);

        // Release reset with the write still presented; only r4 bypasses
        reset = 1'b1;
        for (int i = 1; i < 32; i++) begin
            bus_if.rt_addr = 5'(i);
            #0.1;
            check($sformatf("post_rst_r%0d", i), bus_if.rt_data, (i == 4) ? 32'h55 : 32'h0);
        end
        tick();
        idle();
        set_rd(5'd4, 5'd1);
        check("rel_write_r4", bus_if.rs_data, 32'h0000_0055);
        check("rel_r1_zero", bus_if.rt_data, 32'h0);

        // ALU write to rd=5
        drive_wb(1'b1, 1'b1, 5'd3, 5'd5, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_0000);
        set_rd(5'd0, 5'd0);
        check("alu_wb_valid", {31'h0, bus_if.wb_valid}, 32'd1);
        check("alu_wb_addr", {27'h0, bus_if.wb_addr}, 32'd5);
        check("alu_wb_data", bus_if.wb_data, 32'hDEAD_BEEF);
        tick();
        idle();
        set_rd(5'd5, 5'd3);
        check("alu_rs5", bus_if.rs_data, 32'hDEAD_BEEF);
        check("alu_rt3_untouched", bus_if.rt_data, 32'h0);

        // Load write to rt=9, observed through bypass on both ports
        drive_wb(1'b1, 1'b0, 5'd9, 5'd5, 1'b1, 32'h0000_0BAD, 32'h1234_5678);
        set_rd(5'd9, 5'd9);
        check("ld_wb_addr", {27'h0, bus_if.wb_addr}, 32'd9);
        check("ld_bypass_rt9", bus_if.rt_data, 32'h1234_5678);
        check("ld_bypass_rs9", bus_if.rs_data, 32'h1234_5678);
        tick();
        idle();
        set_rd(5'd5, 5'd9);
        check("ld_rt9_stored", bus_if.rt_data, 32'h1234_5678);
        check("ld_rs5_kept", bus_if.rs_data, 32'hDEAD_BEEF);

        // Enable off: r7 holds 0x11 against a disabled write
        drive_wb(1'b1, 1'b1, 5'd0, 5'd7, 1'b0, 32'h0000_0011, 32'h0);
        tick();
        drive_wb(1'b0, 1'b1, 5'd0, 5'd7, 1'b0, 32'hAAAA_5555, 32'hAAAA_5555);
        set_rd(5'd7, 5'd7);
        check("dis_wb_valid", {31'h0, bus_if.wb_valid}, 32'd0);
        check("dis_rs7_before", bus_if.rs_data, 32'h0000_0011);
        tick();
        #1;
        check("dis_rt7_after", bus_if.rt_data, 32'h0000_0011);

        // Writes to r0 are dropped
        drive_wb(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0);
        set_rd(5'd0, 5'd0);
        check("r0_wb_valid", {31'h0, bus_if.wb_valid}, 32'd0);
        check("r0_rs_before", bus_if.rs_data, 32'h0);
        check("r0_rt_before", bus_if.rt_data, 32'h0);
        tick();
        idle();
        #1;
        check("r0_rs_after", bus_if.rs_data, 32'h0);

        // Back-to-back writes to r10: last one wins
        drive_wb(1'b1, 1'b1, 5'd0, 5'd10, 1'b0, 32'h0000_0100, 32'h0);
        tick();
        drive_wb(1'b1, 1'b0, 5'd10, 5'd0, 1'b1, 32'h0, 32'h0000_0200);
        tick();
        idle();
        set_rd(5'd10, 5'd10);
        check("b2b_r10", bus_if.rs_data, 32'h0000_0200);

        // Async reset mid-cycle clears r3 without a clock edge
        drive_wb(1'b1, 1'b1, 5'd0, 5'd3, 1'b0, 32'h0000_0001, 32'h0);
        tick();
        idle();
        set_rd(5'd3, 5'd5);
        check("ar_r3_set", bus_if.rs_data, 32'h0000_0001);
        #1;
        reset = 1'b0;
        #0.5;
        check("ar_r3_cleared", bus_if.rs_data, 32'h0);
        check("ar_r5_cleared", bus_if.rt_data, 32'h0);

        // A write presented during reset is discarded
        drive_wb(1'b1, 1'b1, 5'd0, 5'd6, 1'b0, 32'h0000_0066, 32'h0);
        tick();
        idle();
        reset = 1'b1;
        set_rd(5'd6, 5'd10);
        check("ar_r6_discarded", bus_if.rs_data, 32'h0);
        check("ar_r10_cleared", bus_if.rt_data, 32'h0);
        tick();
        #1;
        check("ar_r6_still_zero", bus_if.rs_data, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
